// File: rtl/cache_control_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types: shared types for the LC-3b cache controller.
//   lc3b_cache_state : controller FSM state encoding.
//   sel_dirty()      : dirty bit of a chosen way, used to decide whether a
//                      miss must write the victim back before refilling.
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } lc3b_cache_state;

  // way = 0 selects way1, way = 1 selects way2
  function automatic logic sel_dirty(input logic way,
                                     input logic dirty1,
                                     input logic dirty2);
    return way ? dirty2 : dirty1;
  endfunction

endpackage

// File: rtl/cache_control_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear
//   inc   : count enable for this cycle
//   count : current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// ---------------------------------------------------------------------------
// cache_control: control FSM for the LC-3b 2-way set-associative,
// write-back, write-allocate cache.
//
// Ports
//   clk, reset                      clock / asynchronous active-high reset
//   mem_read, mem_write, mem_resp   CPU handshake (resp is a 1-cycle pulse)
//   pmem_read, pmem_write, pmem_resp  physical memory handshake
//   hit, hit_way, lru_out,
//   dirty1_out, dirty2_out          datapath status for the current index
//   load_* / *_in                   array write strobes and write data
//   eviction                        datapath way select: victim vs hit way
//   data_sel                        data-in: 0 = CPU merge, 1 = pmem line
//   pmem_addr_sel                   pmem addr: 0 = request, 1 = victim tag
//   hit_count, miss_count           saturating performance counters
//
// A miss latches the LRU way as the victim; WRITEBACK/ALLOCATE steer every
// strobe from that latched victim. After a fill the FSM returns to IDLE,
// where the now-hitting request is served (and a write merged) normally.
// ---------------------------------------------------------------------------
module cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,

  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,

  input  logic                 hit,
  input  logic                 hit_way,
  input  logic                 lru_out,
  input  logic                 dirty1_out,
  input  logic                 dirty2_out,

  output logic                 load_tag1,
  output logic                 load_tag2,
  output logic                 load_valid1,
  output logic                 load_valid2,
  output logic                 load_data1,
  output logic                 load_data2,
  output logic                 load_dirty1,
  output logic                 load_dirty2,
  output logic                 load_lru,
  output logic                 valid1_in,
  output logic                 valid2_in,
  output logic                 dirty1_in,
  output logic                 dirty2_in,
  output logic                 lru_in,
  output logic                 eviction,
  output logic                 data_sel,
  output logic                 pmem_addr_sel,

  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  lc3b_cache_state state_q, state_d;
  logic            victim_q, victim_d;
  // pending: the current request already missed, so its eventual hit in
  // IDLE is the tail of a miss and must not count as a hit
  logic            pending_q, pending_d;
  logic            hit_inc;
  logic            miss_inc;
  logic            req;

  // a simultaneous read+write is treated as a write, so only mem_write
  // decides the write path
  assign req = mem_read | mem_write;

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    pending_d     = pending_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;

    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    load_tag1     = 1'b0;
    load_tag2     = 1'b0;
    load_valid1   = 1'b0;
    load_valid2   = 1'b0;
    load_data1    = 1'b0;
    load_data2    = 1'b0;
    load_dirty1   = 1'b0;
    load_dirty2   = 1'b0;
    load_lru      = 1'b0;
    valid1_in     = 1'b0;
    valid2_in     = 1'b0;
    dirty1_in     = 1'b0;
    dirty2_in     = 1'b0;
    lru_in        = 1'b0;
    eviction      = 1'b0;
    data_sel      = 1'b0;
    pmem_addr_sel = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!req) begin
          pending_d = 1'b0;
        end else if (hit) begin
          mem_resp  = 1'b1;
          load_lru  = 1'b1;
          lru_in    = ~hit_way;
          hit_inc   = ~pending_q;
          pending_d = 1'b0;
          if (mem_write) begin
            data_sel = 1'b0;
            if (hit_way) begin
              load_data2  = 1'b1;
              load_dirty2 = 1'b1;
              dirty2_in   = 1'b1;
            end else begin
              load_data1  = 1'b1;
              load_dirty1 = 1'b1;
              dirty1_in   = 1'b1;
            end
          end
        end else begin
          victim_d  = lru_out;
          pending_d = 1'b1;
          miss_inc  = 1'b1;
          state_d   = sel_dirty(lru_out, dirty1_out, dirty2_out) ?
                      WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        eviction      = 1'b1;
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) begin
          state_d = ALLOCATE;
        end
      end

      ALLOCATE: begin
        eviction      = 1'b1;
        pmem_read     = 1'b1;
        pmem_addr_sel = 1'b0;
        if (pmem_resp) begin
          data_sel = 1'b1;
          if (victim_q) begin
            load_data2  = 1'b1;
            load_tag2   = 1'b1;
            load_valid2 = 1'b1;
            load_dirty2 = 1'b1;
            valid2_in   = 1'b1;
            dirty2_in   = 1'b0;
          end else begin
            load_data1  = 1'b1;
            load_tag1   = 1'b1;
            load_valid1 = 1'b1;
            load_dirty1 = 1'b1;
            valid1_in   = 1'b1;
            dirty1_in   = 1'b0;
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      victim_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      victim_q  <= victim_d;
      pending_q <= pending_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule
